// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared types and helpers for the Wishbone burst master
// Contents: state enum, slave-response priority encoding, beat address step.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } wb_state_e;

    // Larger encoding wins when a slave asserts several responses at once.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_RTY  = 2'd1,
        RSP_ACK  = 2'd2,
        RSP_ERR  = 2'd3
    } wb_rsp_e;

    function automatic wb_rsp_e wb_resolve(input logic ack, input logic err, input logic rty);
        if (err) return RSP_ERR;
        if (ack) return RSP_ACK;
        if (rty) return RSP_RTY;
        return RSP_NONE;
    endfunction

    // Byte distance between consecutive beats of an incrementing burst.
    function automatic int unsigned beat_incr(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// rtl/wb_burst_master_if.sv - Wishbone B4 classic bus bundle with master/slave views
// Signals are named from the master's side (_o driven by master, _i driven by slave).
// Parameters: DATA_W data width, ADDR_W byte-address width, TAGSIZE tag width.
interface wb_burst_master_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TAGSIZE = 2
);
    logic [DATA_W-1:0]   wb_dat_i;
    logic [TAGSIZE-1:0]  wb_tgd_i;
    logic [DATA_W-1:0]   wb_dat_o;
    logic [TAGSIZE-1:0]  wb_tgd_o;
    logic [ADDR_W-1:0]   wb_adr_o;
    logic [TAGSIZE-1:0]  wb_tga_o;
    logic [TAGSIZE-1:0]  wb_tgc_o;
    logic                wb_ack_i;
    logic                wb_err_i;
    logic                wb_rty_i;
    logic                wb_cyc_o;
    logic                wb_lock_o;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic                wb_gnt_i;

    modport master (
        input  wb_dat_i, wb_tgd_i, wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i,
        output wb_dat_o, wb_tgd_o, wb_adr_o, wb_tga_o, wb_tgc_o,
               wb_cyc_o, wb_lock_o, wb_sel_o, wb_stb_o, wb_we_o
    );

    modport slave (
        output wb_dat_i, wb_tgd_i, wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i,
        input  wb_dat_o, wb_tgd_o, wb_adr_o, wb_tga_o, wb_tgc_o,
               wb_cyc_o, wb_lock_o, wb_sel_o, wb_stb_o, wb_we_o
    );
endinterface

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - Wishbone B4 classic master for single and incrementing bursts
// Ports: clk_i/rst_i (async, active-high); cmd_* command valid/ready port;
//        wdata_* write beat stream in; rdata_* read beat stream out (no backpressure);
//        rsp_valid_o/rsp_err_o one-cycle completion; wb master modport of wb_burst_master_if.
// Optional: define WB_MASTER_TIMEOUT_EN to abort a beat after TIMEOUT_CYC strobe cycles
//           without a slave response.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TAGSIZE     = 2,
    parameter int MAX_BURST   = 8,
    parameter int RETRY_MAX   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [ADDR_W-1:0]            cmd_addr_i,
    input  logic                         cmd_we_i,
    input  logic [DATA_W/8-1:0]          cmd_sel_i,
    input  logic [$clog2(MAX_BURST)-1:0] cmd_len_i,
    input  logic [TAGSIZE-1:0]           cmd_tag_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic                         wdata_valid_i,
    output logic                         wdata_ready_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         rdata_valid_o,
    output logic                         rdata_last_o,
    output logic                         rsp_valid_o,
    output logic                         rsp_err_o,
    wb_burst_master_if.master            wb
);

    localparam int LEN_W = $clog2(MAX_BURST);
    localparam int SEL_W = DATA_W / 8;
    localparam int RET_W = $clog2(RETRY_MAX + 1);

    wb_state_e            state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 we_q;
    logic [SEL_W-1:0]     sel_q;
    logic [LEN_W-1:0]     len_q;
    logic [TAGSIZE-1:0]   tag_q;
    logic [LEN_W-1:0]     beat_q;
    logic [RET_W-1:0]     retry_q;
    logic                 rty_gap_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rdata_valid_q;
    logic                 rdata_last_q;
    logic                 rsp_err_q;

    logic    in_bus;
    logic    stb;
    logic    last_beat;
    wb_rsp_e rsp;

    assign in_bus    = (state_q == BUS);
    assign last_beat = (beat_q == len_q);
    // A retried beat sits out exactly one cycle before it is reissued.
    assign stb       = in_bus && !rty_gap_q && wb.wb_gnt_i && (!we_q || wdata_valid_i);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (!in_bus || rsp != RSP_NONE) begin
            to_cnt_q <= '0;
        end else if (stb) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`endif

    // Slave responses only count while the master is strobing; retry
    // exhaustion and timeout both fold into the error path.
    always_comb begin
        rsp = stb ? wb_resolve(wb.wb_ack_i, wb.wb_err_i, wb.wb_rty_i) : RSP_NONE;
        if (rsp == RSP_RTY && retry_q == RET_W'(RETRY_MAX)) begin
            rsp = RSP_ERR;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        if (stb && rsp == RSP_NONE && to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
            rsp = RSP_ERR;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            len_q         <= '0;
            tag_q         <= '0;
            beat_q        <= '0;
            retry_q       <= '0;
            rty_gap_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            rty_gap_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q  <= cmd_addr_i;
                        we_q    <= cmd_we_i;
                        sel_q   <= cmd_sel_i;
                        len_q   <= cmd_len_i;
                        tag_q   <= cmd_tag_i;
                        beat_q  <= '0;
                        retry_q <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    case (rsp)
                        RSP_ACK: begin
                            addr_q  <= addr_q + ADDR_W'(beat_incr(DATA_W));
                            beat_q  <= beat_q + 1'b1;
                            retry_q <= '0;
                            if (!we_q) begin
                                rdata_q       <= wb.wb_dat_i;
                                rdata_valid_q <= 1'b1;
                                rdata_last_q  <= last_beat;
                            end
                            if (last_beat) begin
                                rsp_err_q <= 1'b0;
                                state_q   <= RESP;
                            end
                        end
                        RSP_ERR: begin
                            retry_q <= '0;
                            // The failing write beat was consumed; the rest
                            // of the burst still has to be pulled and dropped.
                            if (we_q && !last_beat) begin
                                beat_q  <= beat_q + 1'b1;
                                state_q <= DRAIN;
                            end else begin
                                rsp_err_q <= 1'b1;
                                state_q   <= RESP;
                            end
                        end
                        RSP_RTY: begin
                            retry_q   <= retry_q + 1'b1;
                            rty_gap_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                DRAIN: begin
                    if (wdata_valid_i) begin
                        if (last_beat) begin
                            rsp_err_q <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign wdata_ready_o = (state_q == DRAIN) ||
                           (in_bus && we_q && (rsp == RSP_ACK || rsp == RSP_ERR));
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_last_o  = rdata_last_q;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_err_o     = (state_q == RESP) && rsp_err_q;

    assign wb.wb_cyc_o  = in_bus;
    assign wb.wb_lock_o = in_bus;
    assign wb.wb_stb_o  = stb;
    assign wb.wb_we_o   = in_bus && we_q;
    assign wb.wb_adr_o  = in_bus ? addr_q : '0;
    assign wb.wb_sel_o  = in_bus ? sel_q : '0;
    assign wb.wb_tga_o  = in_bus ? tag_q : '0;
    assign wb.wb_tgc_o  = in_bus ? tag_q : '0;
    assign wb.wb_dat_o  = (in_bus && we_q) ? wdata_i : '0;
    assign wb.wb_tgd_o  = '0;

    logic unused_ok;
    assign unused_ok = (^wb.wb_tgd_i) ^ TIMEOUT_CYC[0];

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - directed self-checking bench for wb_burst_master
module tb_wb_burst_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 2;
    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_ERR  = 2'd2;
    localparam logic [1:0] R_RTY  = 2'd3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i = '0;
    logic          cmd_we_i = 1'b0;
    logic [3:0]    cmd_sel_i = '0;
    logic [2:0]    cmd_len_i = '0;
    logic [1:0]    cmd_tag_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic          wdata_valid_i = 1'b0;
    logic          wdata_ready_o;
    logic [DW-1:0] rdata_o;
    logic          rdata_valid_o;
    logic          rdata_last_o;
    logic          rsp_valid_o;
    logic          rsp_err_o;

    logic          gnt = 1'b0;
    logic          mon_clr = 1'b1;
    logic [1:0]    script [0:15];
    logic [31:0]   rdat   [0:15];
    logic [3:0]    sp;
    logic [31:0]   adr_log [0:15];
    logic [31:0]   rd_log  [0:15];
    int            stb_cnt, rd_cnt, wd_cnt, rsp_cnt, last_cnt, last_idx;
    int            vecs = 0;
    int            miss = 0;

    always #5 clk_i = ~clk_i;

    wb_burst_master_if #(.DATA_W(DW), .ADDR_W(AW), .TAGSIZE(TW)) wb ();

    assign wb.wb_gnt_i = gnt;
    assign wb.wb_ack_i = (script[sp] == R_ACK);
    assign wb.wb_err_i = (script[sp] == R_ERR);
    assign wb.wb_rty_i = (script[sp] == R_RTY);
    assign wb.wb_dat_i = rdat[sp];
    assign wb.wb_tgd_i = '0;

    wb_burst_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_we_i(cmd_we_i), .cmd_sel_i(cmd_sel_i),
        .cmd_len_i(cmd_len_i), .cmd_tag_i(cmd_tag_i),
        .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_last_o(rdata_last_o),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
        .wb(wb)
    );

    // Scripted slave: one script entry per strobed cycle; bus activity log.
    always @(posedge clk_i) begin
        if (mon_clr) begin
            sp <= '0; stb_cnt <= 0; rd_cnt <= 0; wd_cnt <= 0;
            rsp_cnt <= 0; last_cnt <= 0; last_idx <= -1;
        end else begin
            if (wb.wb_stb_o) begin
                adr_log[stb_cnt[3:0]] <= wb.wb_adr_o;
                stb_cnt <= stb_cnt + 1;
                sp <= sp + 4'd1;
            end
            if (rdata_valid_o) begin
                rd_log[rd_cnt[3:0]] <= rdata_o;
                rd_cnt <= rd_cnt + 1;
                if (rdata_last_o) begin
                    last_cnt <= last_cnt + 1;
                    last_idx <= rd_cnt;
                end
            end
            if (wdata_ready_o && wdata_valid_i) wd_cnt <= wd_cnt + 1;
            if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prep();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            script[i] = R_NONE;
            rdat[i]   = '0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [2:0] l, input logic [1:0] t);
        int n = 0;
        while (!cmd_ready_o && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        cmd_addr_i = a; cmd_we_i = w; cmd_sel_i = s; cmd_len_i = l; cmd_tag_i = t;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid_o && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            script[i] = R_NONE;
            rdat[i]   = '0;
        end
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_rdata_valid", {31'd0, rdata_valid_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        check("idle_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Single write, immediate grant and ack.
        prep();
        script[0] = R_ACK;
        gnt = 1'b1; wdata_i = 32'hDEADBEEF; wdata_valid_i = 1'b1;
        issue(32'h100, 1'b1, 4'hF, 3'd0, 2'd2);
        check("w1_stb", {31'd0, wb.wb_stb_o}, 32'd1);
        check("w1_adr", wb.wb_adr_o, 32'h100);
        check("w1_dat", wb.wb_dat_o, 32'hDEADBEEF);
        check("w1_sel", {28'd0, wb.wb_sel_o}, 32'hF);
        check("w1_we_lock", {30'd0, wb.wb_we_o, wb.wb_lock_o}, 32'd3);
        check("w1_tga", {30'd0, wb.wb_tga_o}, 32'd2);
        check("w1_wready", {31'd0, wdata_ready_o}, 32'd1);
        tick();
        check("w1_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'b10);
        check("w1_cyc_done", {31'd0, wb.wb_cyc_o}, 32'd0);
        wdata_valid_i = 1'b0;
        tick();
        check("w1_rsp_pulse", {31'd0, rsp_valid_o}, 32'd0);

        // Read burst of 4 wrapping the address space.
        prep();
        for (int i = 0; i < 4; i++) begin
            script[i] = R_ACK;
            rdat[i]   = i + 1;
        end
        issue(32'hFFFF_FFF8, 1'b0, 4'hF, 3'd3, 2'd1);
        wait_rsp(n);
        check("r4_latency", n, 32'd4);
        check("r4_err", {31'd0, rsp_err_o}, 32'd0);
        tick();
        check("r4_stb_cnt", stb_cnt, 32'd4);
        check("r4_adr0", adr_log[0], 32'hFFFF_FFF8);
        check("r4_adr1", adr_log[1], 32'hFFFF_FFFC);
        check("r4_adr2", adr_log[2], 32'h0000_0000);
        check("r4_adr3", adr_log[3], 32'h0000_0004);
        check("r4_rd_cnt", rd_cnt, 32'd4);
        check("r4_rd0", rd_log[0], 32'd1);
        check("r4_rd3", rd_log[3], 32'd4);
        check("r4_last_cnt", last_cnt, 32'd1);
        check("r4_last_idx", last_idx, 32'd3);

        // Write burst of 4 with err on beat 1: remaining beats drained off-bus.
        prep();
        script[0] = R_ACK; script[1] = R_ERR;
        wdata_i = 32'h1234_5678; wdata_valid_i = 1'b1;
        issue(32'h200, 1'b1, 4'h3, 3'd3, 2'd0);
        wait_rsp(n);
        check("werr_latency", n, 32'd4);
        check("werr_err", {31'd0, rsp_err_o}, 32'd1);
        wdata_valid_i = 1'b0;
        tick();
        check("werr_stb_cnt", stb_cnt, 32'd2);
        check("werr_wd_cnt", wd_cnt, 32'd4);

        // Read with two retries then ack.
        prep();
        script[0] = R_RTY; script[1] = R_RTY; script[2] = R_ACK; rdat[2] = 32'hA5;
        issue(32'h40, 1'b0, 4'hF, 3'd0, 2'd0);
        wait_rsp(n);
        check("rty2_latency", n, 32'd5);
        check("rty2_err", {31'd0, rsp_err_o}, 32'd0);
        tick();
        check("rty2_stb_cnt", stb_cnt, 32'd3);
        check("rty2_adr0", adr_log[0], 32'h40);
        check("rty2_adr2", adr_log[2], 32'h40);
        check("rty2_rd", rd_log[0], 32'hA5);

        // Four retries exhaust the budget.
        prep();
        for (int i = 0; i < 4; i++) script[i] = R_RTY;
        issue(32'h44, 1'b0, 4'hF, 3'd0, 2'd0);
        wait_rsp(n);
        check("rty4_latency", n, 32'd7);
        check("rty4_err", {31'd0, rsp_err_o}, 32'd1);
        tick();
        check("rty4_stb_cnt", stb_cnt, 32'd4);
        check("rty4_rd_cnt", rd_cnt, 32'd0);

        // Write of 2 beats with grant gap then write-data gap.
        prep();
        script[0] = R_ACK; script[1] = R_ACK;
        wdata_i = 32'h0BAD_F00D; wdata_valid_i = 1'b1; gnt = 1'b1;
        issue(32'h300, 1'b1, 4'hF, 3'd1, 2'd0);
        tick();
        gnt = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("gnt_gap_stb_cyc", {30'd0, wb.wb_stb_o, wb.wb_cyc_o}, 32'b01);
            tick();
        end
        gnt = 1'b1; wdata_valid_i = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("wv_gap_stb_cyc", {30'd0, wb.wb_stb_o, wb.wb_cyc_o}, 32'b01);
            tick();
        end
        wdata_valid_i = 1'b1;
        #1;
        check("gap_adr1", wb.wb_adr_o, 32'h304);
        tick();
        check("gap_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'b10);
        wdata_valid_i = 1'b0;
        tick();
        check("gap_stb_cnt", stb_cnt, 32'd2);
        check("gap_wd_cnt", wd_cnt, 32'd2);

        // Reset while the second of four read beats is stalled.
        prep();
        script[0] = R_ACK; rdat[0] = 32'h11;
        issue(32'h400, 1'b0, 4'hF, 3'd3, 2'd0);
        tick();
        check("rst_mid_stb_before", {31'd0, wb.wb_stb_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_bus", {29'd0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_lock_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        check("rst_mid_no_rsp", rsp_cnt, 32'd0);
        check("rst_mid_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Single read after reset: data and response both two cycles after the command.
        prep();
        script[0] = R_ACK; rdat[0] = 32'h77;
        issue(32'h500, 1'b0, 4'hF, 3'd0, 2'd0);
        tick();
        check("r1_rvalid_last", {30'd0, rdata_valid_o, rdata_last_o}, 32'b11);
        check("r1_rdata", rdata_o, 32'h77);
        check("r1_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'b10);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Parametrised Wishbone B4 classic master for single and incrementing-burst transfers.
- Accepts a command (address, direction, byte select, length, tag) through a valid/ready port.
- Streams write beats in and read beats out, then returns one completion response with an error flag.
- Sits between core load/store units or caches and the shared Wishbone interconnect; adds bounded retry handling and error draining.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8)
ADDR_W, 32, byte-address width
TAGSIZE, 2, width of every Wishbone tag signal
MAX_BURST, 8, maximum beats per command (power of two, >=2)
RETRY_MAX, 3, rty_i responses tolerated per beat before error
TIMEOUT_CYC, 255, cycles without slave response before abort (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when both high
cmd_addr_i  in  ADDR_W  start byte address
cmd_we_i  in  1  1=write, 0=read
cmd_sel_i  in  DATA_W/8  byte select, used for all beats
cmd_len_i  in  $clog2(MAX_BURST)  beats minus one
cmd_tag_i  in  TAGSIZE  driven on wb_tga_o/wb_tgc_o
wdata_i  in  DATA_W  write beat
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat consumed
rdata_o  out  DATA_W  read beat, registered
rdata_valid_o  out  1  read beat valid, no backpressure
rdata_last_o  out  1  final read beat
rsp_valid_o  out  1  one-cycle completion pulse
rsp_err_o  out  1  command failed (err, retry exhaustion, timeout)
wb_dat_i  in  DATA_W
wb_tgd_i  in  TAGSIZE (ignored)
wb_dat_o  out  DATA_W
wb_tgd_o  out  TAGSIZE (tied 0)
wb_adr_o  out  ADDR_W
wb_tga_o  out  TAGSIZE
wb_tgc_o  out  TAGSIZE
wb_ack_i  in  1
wb_err_i  in  1
wb_rty_i  in  1
wb_cyc_o  out  1
wb_lock_o  out  1
wb_sel_o  out  DATA_W/8
wb_stb_o  out  1
wb_we_o  out  1
wb_gnt_i  in  1  bus grant

Behaviour:
- Reset: rst_i asynchronous, active-high; clock clk_i.
  - Reset clears all outputs, all counters and the state (IDLE).
  - Reset mid-burst drops cyc/stb immediately; no response is issued.
- Registered state machine; Wishbone outputs combinational from registered state plus gnt/wdata_valid.
- IDLE:
  - cmd_ready_o=1.
  - On handshake, latch addr/we/sel/len/tag and clear beat and retry counters; go to BUS.
- BUS:
  - wb_cyc_o=1 and wb_lock_o=1 for the whole burst.
  - wb_adr_o=latched address; wb_sel_o=latched sel; wb_we_o=latched we.
  - wb_stb_o=wb_gnt_i && (read || wdata_valid_i). Write: wb_dat_o=wdata_i.
  - Response priority: err > ack > rty.
  - ack: wdata_ready_o=1 (write); beat++; address += DATA_W/8, modulo 2^ADDR_W; retry counter cleared.
    - Read: rdata_o<=wb_dat_i, rdata_valid_o pulses next cycle.
    - If beat==len, last beat → RESP, err=0; rdata_last_o set with the final read beat.
  - err: write → DRAIN if beats remain, else RESP err=1; read → RESP err=1.
  - rty: retry++; stb low for one cycle, then same beat reissued. Reaching RETRY_MAX is treated as err.
  - gnt_i low: stb low; no beat or counter advance; cyc held.
- DRAIN: wdata_ready_o=1, cyc=0; discard remaining write beats until count reached → RESP err=1.
- RESP: rsp_valid_o=1 for one cycle with rsp_err_o → IDLE.
  - Earliest new command is accepted in the following IDLE cycle.
- Latency:
  - Single read, gnt and ack in first BUS cycle: rdata_valid_o at T+2, rsp_valid_o at T+2 (T = command handshake).
  - Back-to-back acks sustain one beat per cycle.

Optional Feature:
WB_MASTER_TIMEOUT_EN
- Defined: counter resets on any slave response or beat advance; increments while stb high.
  - At TIMEOUT_CYC, the beat aborts as err (same path, including DRAIN).
- Undefined: no counter; master waits indefinitely; TIMEOUT_CYC unused.

Decomposition:
- Package wb_master_pkg holds:
  - state enum {IDLE, BUS, DRAIN, RESP};
  - response priority constants;
  - function for beat address increment.
- No sub-module required; the timeout counter stays inline under the macro.

Test Plan:
- Write len=0, addr 0x100, sel 0xF, data 0xDEADBEEF, immediate gnt+ack → one stb with that adr/dat; rsp_valid_o, rsp_err_o=0 two cycles after command.
- Read len=3, addr 0xFFFFFFF8, slave returns 1,2,3,4 → adr 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; rdata 1..4; rdata_last_o on 4; rsp err=0.
- Write len=3, err on beat 1 → DRAIN consumes beats 2,3 with no stb; rsp_err_o=1.
- Read len=0, rty twice then ack → three stb assertions, same address; rsp err=0. Four rty → rsp_err_o=1.
- Write len=1, gnt low 5 cycles mid-burst, then wdata_valid_i low 2 cycles → stb low in both gaps, cyc held, two acks total, rsp err=0.
- Reset asserted during beat 2 of 4 → cyc/stb/lock low same cycle; no rsp_valid_o; next command completes normally.
